// File: rtl/align_norm_shifter.sv
// Two-stage valid/ready shifter for the float adder mantissa path.
// Mode 0 right-aligns {data,2'b00} and captures guard/round/sticky.
// Mode 1 left-normalises by the leading-zero count and reports that count.
// Stage 1 holds the operand and the resolved shift amount.
// Stage 2 holds the shifted result, which drives out_* directly.
module align_norm_shifter #(
  parameter int WIDTH   = 10,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_guard,
  output logic               out_round,
  output logic               out_sticky,
  output logic [SHIFT_W-1:0] out_lzc,
  output logic               out_zero
);

  localparam int                 EXT_W  = WIDTH + 2;
  localparam logic [SHIFT_W-1:0] EXT_SH = SHIFT_W'(EXT_W);

  logic               s1_valid_q, s1_mode_q, s1_zero_q;
  logic [WIDTH-1:0]   s1_data_q;
  logic [SHIFT_W-1:0] s1_sh_q;

  logic               s2_valid_q, guard_q, round_q, sticky_q, zero_q;
  logic [WIDTH-1:0]   data_q;
  logic [SHIFT_W-1:0] lzc_q;

  logic               s1_adv, s2_adv;
  logic [SHIFT_W-1:0] lzc_d, sh_d;
  logic [WIDTH-1:0]   data_d;
  logic               guard_d, round_d, sticky_d;
  logic [2*EXT_W-1:0] wide;

  // Handshake: each stage may load when empty or when its contents move on.
  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  // Leading-zero count; the highest set bit is the last one seen scanning up.
  always_comb begin
    lzc_d = SHIFT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (in_data[i]) lzc_d = SHIFT_W'(WIDTH - 1 - i);
  end

  // Effective shift: the LZC when normalising, clamped shamt when aligning.
  always_comb begin
    if (in_mode)               sh_d = lzc_d;
    else if (in_shamt >= EXT_SH) sh_d = EXT_SH;
    else                       sh_d = in_shamt;
  end

  // Stage 1 register: operand, mode, zero flag and resolved shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_data_q  <= '0;
      s1_sh_q    <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mode_q <= in_mode;
        s1_zero_q <= (in_data == '0);
        s1_data_q <= in_data;
        s1_sh_q   <= sh_d;
      end
    end
  end

  // Shifter: the low half of the wide vector catches every bit pushed past
  // ext[0], so sticky is simply its OR.
  always_comb begin
    wide     = {s1_data_q, {(EXT_W + 2){1'b0}}} >> s1_sh_q;
    data_d   = wide[2*EXT_W-1:EXT_W+2];
    guard_d  = wide[EXT_W+1];
    round_d  = wide[EXT_W];
    sticky_d = |wide[EXT_W-1:0];
    if (s1_mode_q) begin
      data_d   = s1_data_q << s1_sh_q;
      guard_d  = 1'b0;
      round_d  = 1'b0;
      sticky_d = 1'b0;
    end
  end

  // Stage 2 register: result is only replaced when it may advance, so out_*
  // stay stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      data_q     <= '0;
      guard_q    <= 1'b0;
      round_q    <= 1'b0;
      sticky_q   <= 1'b0;
      lzc_q      <= '0;
      zero_q     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        data_q   <= data_d;
        guard_q  <= guard_d;
        round_q  <= round_d;
        sticky_q <= sticky_d;
        lzc_q    <= s1_sh_q;
        zero_q   <= s1_zero_q;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_data   = data_q;
  assign out_guard  = guard_q;
  assign out_round  = round_q;
  assign out_sticky = sticky_q;
  assign out_lzc    = lzc_q;
  assign out_zero   = zero_q;

endmodule

// File: tb/tb_align_norm_shifter.sv
// Scoreboard bench for align_norm_shifter (WIDTH=10, SHIFT_W=5).
module tb_align_norm_shifter;

  localparam int W  = 10;
  localparam int SW = 5;

  typedef struct packed {
    logic [W-1:0]  data;
    logic          g, r, s;
    logic [SW-1:0] lzc;
    logic          zero;
  } res_t;

  logic          clk = 0, rst = 1;
  logic          in_valid = 0, in_ready, in_mode = 0;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_shamt = '0;
  logic          out_valid, out_ready = 1;
  logic [W-1:0]  out_data;
  logic          out_guard, out_round, out_sticky, out_zero;
  logic [SW-1:0] out_lzc;

  align_norm_shifter #(.WIDTH(W), .SHIFT_W(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_shamt(in_shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_guard(out_guard), .out_round(out_round),
    .out_sticky(out_sticky), .out_lzc(out_lzc), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  int   checks = 0, fails = 0;
  int   pops = 0, neg_cnt = 0, stall_cnt = 0;
  res_t sb[$];
  int   pop_t[$];
  res_t held;
  logic hold_valid = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: integer arithmetic straight from the mode rules.
  function automatic res_t model(input logic mode, input logic [W-1:0] d, input logic [SW-1:0] sh);
    res_t e;
    int   s, full, v, z, t;
    e = '0;
    e.zero = (d == 0);
    if (!mode) begin
      s      = (int'(sh) > W + 2) ? W + 2 : int'(sh);
      full   = int'(d) * 4;
      v      = full >> s;
      e.data = W'(v >> 2);
      e.g    = v[1];
      e.r    = v[0];
      e.s    = (full % (1 << s)) != 0;
      e.lzc  = SW'(s);
    end else begin
      z = 0;
      t = int'(d);
      while (z < W && t < (1 << (W - 1))) begin
        t = t * 2;
        z++;
      end
      e.data = W'((int'(d) << z) & ((1 << W) - 1));
      e.lzc  = SW'(z);
    end
    return e;
  endfunction

  function automatic res_t got_now();
    res_t g;
    g.data = out_data; g.g = out_guard; g.r = out_round; g.s = out_sticky;
    g.lzc  = out_lzc;  g.zero = out_zero;
    return g;
  endfunction

  // Monitor: inputs only change just after posedge, so negedge values are
  // exactly what the next edge will see.
  always @(negedge clk) begin
    neg_cnt++;
    if (!rst) begin
      if (hold_valid) begin
        chk("stall_valid_held", out_valid, 1'b1);
        chk("stall_data_held", got_now(), held);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", 1'b1, 1'b0);
        else chk("result", got_now(), sb.pop_front());
        pops++;
        pop_t.push_back(neg_cnt);
      end
      hold_valid = out_valid && !out_ready;
      held       = got_now();
      if (!in_ready) stall_cnt++;
    end else hold_valid = 0;
  end

  task automatic send(input logic mode, input logic [W-1:0] d, input logic [SW-1:0] sh);
    bit ok = 0;
    in_mode = mode; in_data = d; in_shamt = sh; in_valid = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("in_ready_timeout", 1'b0, 1'b1);
    else sb.push_back(model(mode, d, sh));
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin @(negedge clk); k++; end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, stall0, pops0;
    bit done;
    // Reset state
    rst = 1; out_ready = 1;
    repeat (3) @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_lzc", out_lzc, 0);
    chk("rst_grs", {out_guard, out_round, out_sticky}, 0);
    chk("rst_out_zero", out_zero, 0);
    @(posedge clk); #1;

    // Directed cases: align, clamp, passthrough, normalise corners
    send(0, 10'h201, 5'd3);
    send(0, 10'h3FF, 5'd31);
    send(0, 10'h2AA, 5'd0);
    send(0, 10'h3FF, 5'd12);
    send(0, 10'h3FF, 5'd11);
    send(0, 10'h000, 5'd4);
    send(1, 10'h005, 5'd9);
    send(1, 10'h000, 5'd0);
    send(1, 10'h200, 5'd0);
    send(1, 10'h001, 5'd0);
    drain();

    // Backpressure: 6 beats, out_ready low for cycles 3-6
    stall0 = stall_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(1'(i & 1), W'($urandom), SW'($urandom_range(0, 15)));
      end
      begin
        out_ready = 1;
        repeat (2) @(posedge clk); #1;
        out_ready = 0;
        repeat (4) @(posedge clk); #1;
        out_ready = 1;
      end
    join
    drain();
    chk("bp_in_ready_dropped", stall_cnt > stall0, 1'b1);

    // Full-throughput mix: alternate modes, expect one result per cycle
    base = pops;
    for (int i = 0; i < 20; i++)
      send(1'(i & 1), W'($urandom), SW'($urandom_range(0, 14)));
    drain();
    chk("mix_count", 64'(pops - base), 20);
    if (pops - base == 20) chk("mix_throughput", 64'(pop_t[base + 19] - pop_t[base]), 19);

    // Randomized stream with random backpressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          logic [W-1:0] d;
          case ($urandom_range(0, 5))
            0: d = '0;
            1: d = '1;
            2: d = W'(1) << $urandom_range(0, W - 1);
            default: d = W'($urandom);
          endcase
          send(1'($urandom), d, SW'($urandom_range(0, 31)));
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    drain();

    // Reset mid-flight: two beats buffered, then flushed
    out_ready = 0;
    send(0, 10'h155, 5'd2);
    send(1, 10'h013, 5'd0);
    rst = 1;
    @(posedge clk); #1;
    sb.delete();
    rst = 0;
    out_ready = 1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    pops0 = pops;
    repeat (10) @(negedge clk);
    chk("midrst_no_stale", 64'(pops - pops0), 0);
    @(posedge clk); #1;
    send(1, 10'h013, 5'd0);
    drain();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
